// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and a
// constant-function log2 used to size the bit counter.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2 with a floor of 1 so a counter never collapses to zero bits.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell reused WIDTH times.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cell_d, cell_bout;
    logic             last_bit;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    full_subtractor u_cell (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d  = in_a[WIDTH-1];
                    b_msb_d  = in_b[WIDTH-1];
                    ovf_d    = 1'b0;
`endif
                end
            end
            RUN: begin
                // Result bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                diff_d   = {cell_d, diff_q[WIDTH-1:1]};
                borrow_d = cell_bout;
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_bit) begin
                    state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Handshake flags decode state directly; in_ready stays low through DONE.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table plus
// random operands through a result scoreboard, with backpressure, ignored
// in_valid and mid-run reset sequences.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             ovf;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        exp_t             e;
    } vec_t;

    logic             sys_clk;
    logic             sys_rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t r;
        r.diff   = a - b;
        r.borrow = (a < b);
        r.ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (r.diff[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(negedge sys_clk);
            guard++;
        end
        check("in_ready_idle", in_ready, 1);
    endtask

    // One operation: accept, latency count, optional in_valid poke during RUN,
    // hold cycles of backpressure, then scoreboard compare and return to IDLE.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input exp_t e, input int hold, input bit poke);
        int   lat;
        exp_t got_e;
        wait_idle();
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(posedge sys_clk);
        sb_q.push_back(e);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge sys_clk);
            lat++;
            @(negedge sys_clk);
            if (lat == 1) check("in_ready_busy", in_ready, 0);
            if (poke && lat == 2) begin
                in_valid = 1'b1;
                in_a     = 8'hFF;
                in_b     = 8'h00;
            end
            if (poke && lat == 3) in_valid = 1'b0;
        end while (!out_valid && lat < WIDTH + 4);
        check("latency", lat, WIDTH);
        check("sb_nonempty", (sb_q.size() != 0), 1);
        got_e = (sb_q.size() != 0) ? sb_q[0] : e;
        for (int i = 0; i < hold; i++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            check("hold_valid", out_valid, 1);
            check("hold_diff", diff, got_e.diff);
            check("hold_borrow", borrow, got_e.borrow);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        if (sb_q.size() != 0) got_e = sb_q.pop_front();
        check("out_valid", out_valid, 1);
        check("diff", diff, got_e.diff);
        check("borrow", borrow, got_e.borrow);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", ovf, got_e.ovf);
`endif
        check("in_ready_done", in_ready, 0);
        @(posedge sys_clk);
        #1 out_ready = 1'b0;
        @(negedge sys_clk);
        check("idle_out_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
    endtask

    vec_t vecs[9];

    initial begin
        bit   seen;
        exp_t re;
        logic [WIDTH-1:0] ra, rb;

        vecs[0] = '{a: 8'h05, b: 8'h03, e: '{diff: 8'h02, borrow: 1'b0, ovf: 1'b0}};
        vecs[1] = '{a: 8'h03, b: 8'h05, e: '{diff: 8'hFE, borrow: 1'b1, ovf: 1'b0}};
        vecs[2] = '{a: 8'h80, b: 8'h01, e: '{diff: 8'h7F, borrow: 1'b0, ovf: 1'b1}};
        vecs[3] = '{a: 8'h00, b: 8'h00, e: '{diff: 8'h00, borrow: 1'b0, ovf: 1'b0}};
        vecs[4] = '{a: 8'hFF, b: 8'hFF, e: '{diff: 8'h00, borrow: 1'b0, ovf: 1'b0}};
        vecs[5] = '{a: 8'h00, b: 8'hFF, e: '{diff: 8'h01, borrow: 1'b1, ovf: 1'b0}};
        vecs[6] = '{a: 8'h7F, b: 8'h80, e: '{diff: 8'hFF, borrow: 1'b1, ovf: 1'b1}};
        vecs[7] = '{a: 8'hFF, b: 8'h01, e: '{diff: 8'hFE, borrow: 1'b0, ovf: 1'b0}};
        vecs[8] = '{a: 8'hA5, b: 8'h5A, e: '{diff: 8'h4B, borrow: 1'b0, ovf: 1'b1}};

        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].e, (i == 1) ? 5 : 0, 1'b0);
        end

        for (int i = 0; i < 6; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            re = model(ra, rb);
            do_op(ra, rb, re, $urandom_range(0, 2), 1'b0);
        end

        // in_valid pulsed mid-RUN must be dropped, not queued as a second op.
        re = model(8'h20, 8'h08);
        do_op(8'h20, 8'h08, re, 0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < WIDTH + 3; i++) begin
            @(negedge sys_clk);
            if (out_valid) seen = 1'b1;
        end
        check("no_second_result", seen, 0);
        check("ignored_in_ready", in_ready, 1);

        // Reset while bit 4 is being resolved discards the partial result.
        wait_idle();
        in_valid = 1'b1;
        in_a     = 8'h37;
        in_b     = 8'h12;
        @(posedge sys_clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge sys_clk);
        @(negedge sys_clk);
        check("pre_rst_busy", in_ready, 0);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_diff", diff, 0);
        check("midrst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("midrst_ovf", ovf, 0);
`endif
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        do_op(8'h10, 8'h01, '{diff: 8'h0F, borrow: 1'b0, ovf: 1'b0}, 0, 1'b0);

        check("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned/two's-complement subtractor computing A − B one bit per clock, LSB first, with a registered borrow between bits. It is the inverse arithmetic partner of the team's full-adder datapath. It trades latency for area: one 1-bit full-subtractor cell is reused WIDTH times. Operands enter and results leave through valid/ready handshakes so it can sit between streaming blocks.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32
- sys_clk  in  1  single system clock, rising-edge
- sys_rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_a  in  WIDTH  minuend
- in_b  in  WIDTH  subtrahend
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  downstream accepts result
- diff  out  WIDTH  (in_a − in_b) mod 2^WIDTH
- borrow  out  1  1 iff in_a < in_b (unsigned)
- ovf  out  1  signed overflow flag; present only with SERIAL_SUB_OVF_EN

## Operation
- FSM states: IDLE, RUN, DONE; reset state IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_a/in_b into shift registers, clear borrow register, clear bit counter, go RUN.
- RUN: each cycle the full-subtractor cell takes a[0], b[0], borrow_reg; difference bit shifts into diff register MSB-side (right shift), borrow_reg updates, operand registers shift right, counter increments.
- After bit WIDTH−1 is processed, go DONE; borrow output = final borrow_reg.
- DONE: out_valid=1; diff/borrow/ovf stable. On out_valid&out_ready go IDLE.
- in_valid outside IDLE is ignored, not queued; operands must be re-presented.
- Cell equations: d = x^y^bin; bout = (~x&y) | (~(x^y)&bin).
- ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using latched original MSBs.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, diff=0, borrow=0, ovf=0; counter, shift regs and borrow_reg = 0.
- Accept at edge E0; bit i resolved at edge E(i+1); state enters DONE at edge E_WIDTH; out_valid high in the cycle after E_WIDTH.
- Latency: WIDTH cycles from accept edge to out_valid. Minimum op period: WIDTH+2 cycles (accept, WIDTH RUN cycles, ≥1 DONE cycle, back in IDLE).
- in_ready is a combinational decode of state==IDLE; low during RUN and DONE, so no same-cycle accept on the cycle a result is taken.
- out_ready held low: stay in DONE indefinitely, outputs unchanged.
- Reset asserted mid-RUN or DONE: immediately return to IDLE with all reset values; partial result discarded.
- diff is only meaningful while out_valid=1; it holds its last value in IDLE until the next result overwrites it.

## Configuration
- SERIAL_SUB_OVF_EN defined: ovf port exists, MSB registers for a and b are kept, ovf is registered at the RUN→DONE transition and holds through DONE.
- Undefined: no ovf port, no MSB capture logic; all other behaviour identical.

## Structure
- Shared package serial_sub_pkg: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a clog2 function for counter width.
- One sub-module: full_subtractor (x, y, bin → d, bout), purely combinational, instantiated once.

## Test plan
- WIDTH=8, a=0x05, b=0x03, out_ready=1 → out_valid exactly 8 cycles after accept, diff=0x02, borrow=0, ovf=0.
- a=0x03, b=0x05 → diff=0xFE, borrow=1, ovf=0.
- a=0x80, b=0x01 (SERIAL_SUB_OVF_EN) → diff=0x7F, borrow=0, ovf=1; a=0x00, b=0x00 → diff=0x00, borrow=0.
- Backpressure: out_ready low for 5 cycles after out_valid → out_valid, diff, borrow held constant; in_ready stays 0; idle one cycle after out_ready rises.
- in_valid pulsed with a=0xFF during RUN → ignored; first result unaffected; no second result produced.
- sys_rst_n driven low at RUN bit 4 → out_valid=0, in_ready=1, diff=0 immediately; next op 0x10−0x01 gives diff=0x0F, borrow=0.
